// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed DIGITS-wide hex 7-segment driver.
// Scans one digit per DIV cycles on a shared segment bus with a one-hot strobe.
// New values are applied only at the frame boundary, so each frame is coherent.
// Build option: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000
) (
    input  logic                CLK,
    input  logic                RST_X,
    input  logic                EN,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] VALUE,
    input  logic [DIGITS-1:0]   DP_IN,
    output logic [7:0]          LED,
    output logic [DIGITS-1:0]   DIG,
    output logic                PENDING,
    output logic                FRAME
);
    localparam int CW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d, shd_val_q, shd_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, shd_dp_q, shd_dp_d;
    logic                pend_q, pend_d, frame_q, frame_d;
    logic [7:0]          led_q, led_d;
    logic [DIGITS-1:0]   dig_q, dig_d;

    logic                cnt_wrap, bnd;
    logic [3:0]          cur_nib;
    logic                cur_dp, cur_blank;
    logic [7:0]          cur_seg;

    function automatic logic [7:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 8'hFC;  4'h1: seg7 = 8'h60;
            4'h2: seg7 = 8'hDA;  4'h3: seg7 = 8'hF2;
            4'h4: seg7 = 8'h66;  4'h5: seg7 = 8'hB6;
            4'h6: seg7 = 8'hBE;  4'h7: seg7 = 8'hE0;
            4'h8: seg7 = 8'hFE;  4'h9: seg7 = 8'hF6;
            4'hA: seg7 = 8'hEE;  4'hB: seg7 = 8'h3E;
            4'hC: seg7 = 8'h1A;  4'hD: seg7 = 8'h7A;
            4'hE: seg7 = 8'h9E;  4'hF: seg7 = 8'h8E;
            default: seg7 = 8'h00;
        endcase
    endfunction

    assign cnt_wrap = (cnt_q == CNT_MAX);
    assign bnd      = cnt_wrap && (idx_q == IDX_MAX);

    // Pick the nibble and decimal point of the digit currently being scanned.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib = disp_val_q[4*i +: 4];
                cur_dp  = disp_dp_q[i];
            end
        end
    end

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] blank;
    logic              lz_acc;

    // A digit above 0 is blank when it and every more significant digit are zero.
    always_comb begin
        blank  = '0;
        lz_acc = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_acc   = lz_acc & (disp_val_q[4*i +: 4] == 4'h0);
            blank[i] = lz_acc;
        end
    end

    // Blank flag of the digit currently being scanned.
    always_comb begin
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) cur_blank = blank[i];
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    assign cur_seg = seg7(cur_nib);

    // Next state: prescaler/scan index, frame-synchronous load, registered outputs.
    always_comb begin
        cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        shd_val_d  = shd_val_q;
        shd_dp_d   = shd_dp_q;
        pend_d     = pend_q;
        frame_d    = 1'b0;

        if (cnt_wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

        if (bnd) begin
            // A load landing on the boundary bypasses the shadow entirely.
            if (LOAD) begin
                disp_val_d = VALUE;
                disp_dp_d  = DP_IN;
                pend_d     = 1'b0;
                frame_d    = 1'b1;
            end else if (pend_q) begin
                disp_val_d = shd_val_q;
                disp_dp_d  = shd_dp_q;
                pend_d     = 1'b0;
                frame_d    = 1'b1;
            end
        end else if (LOAD) begin
            shd_val_d = VALUE;
            shd_dp_d  = DP_IN;
            pend_d    = 1'b1;
        end

        dig_d = EN ? (DIGITS'(1) << idx_q) : '0;
        led_d = (EN && !cur_blank) ? {cur_seg[7:1], cur_dp} : 8'h00;
    end

    // State register; reset aborts the frame and drops any pending value.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            shd_val_q  <= '0;
            shd_dp_q   <= '0;
            pend_q     <= 1'b0;
            frame_q    <= 1'b0;
            led_q      <= 8'h00;
            dig_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            shd_val_q  <= shd_val_d;
            shd_dp_q   <= shd_dp_d;
            pend_q     <= pend_d;
            frame_q    <= frame_d;
            led_q      <= led_d;
            dig_q      <= dig_d;
        end
    end

    assign LED     = led_q;
    assign DIG     = dig_q;
    assign PENDING = pend_q;
    assign FRAME   = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, DIV=4 (16-cycle frame).
// Expected segment patterns are hand-derived; edge_n tracks scan position.
module tb_seg7_scan_driver;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;

    logic        CLK = 1'b0;
    logic        RST_X, EN, LOAD;
    logic [15:0] VALUE;
    logic [3:0]  DP_IN;
    logic [7:0]  LED;
    logic [3:0]  DIG;
    logic        PENDING, FRAME;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;

`ifdef SEG7_LZB_EN
    localparam logic [7:0] Z_HI = 8'h00;   // leading zero digit, blanked
`else
    localparam logic [7:0] Z_HI = 8'hFC;   // leading zero digit, decoded
`endif

    always #5 CLK = ~CLK;

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .CLK(CLK), .RST_X(RST_X), .EN(EN), .LOAD(LOAD), .VALUE(VALUE),
        .DP_IN(DP_IN), .LED(LED), .DIG(DIG), .PENDING(PENDING), .FRAME(FRAME)
    );

    task automatic step();
        @(posedge CLK); #1;
        edge_n++;
    endtask

    // Advance until edge_n % 16 == pos (the next edge then sees idx/cnt = pos).
    task automatic step_until(input int pos);
        for (int k = 0; k < 16; k++) begin
            if (edge_n % 16 == pos) break;
            step();
        end
    endtask

    // Digit index shown on the outputs after edge edge_n.
    function automatic int cur_digit();
        return ((edge_n - 1) / 4) % 4;
    endfunction

    task automatic test_reset();
        RST_X = 1'b0; EN = 1'b1; LOAD = 1'b0; VALUE = '0; DP_IN = '0;
        repeat (3) @(posedge CLK);
        #1 RST_X = 1'b1; edge_n = 0;
        repeat (6) step();
        VALUE = 16'h8888; DP_IN = 4'hF; LOAD = 1'b1; step(); LOAD = 1'b0;
        n_total++;
        if (PENDING !== 1'b1) $display("FAIL pre_reset_pending got %b want 1", PENDING);
        else n_pass++;
        #2 RST_X = 1'b0; #1;
        n_total++;
        if ({LED, DIG, PENDING, FRAME} !== 14'h0)
            $display("FAIL reset_async got LED=%h DIG=%b P=%b F=%b want 00 0000 0 0", LED, DIG, PENDING, FRAME);
        else n_pass++;
        @(posedge CLK); #1;
        n_total++;
        if ({LED, DIG, PENDING, FRAME} !== 14'h0)
            $display("FAIL reset_held got LED=%h DIG=%b P=%b F=%b want 00 0000 0 0", LED, DIG, PENDING, FRAME);
        else n_pass++;
        RST_X = 1'b1; edge_n = 0;
        step();
        n_total++;
        if (DIG !== 4'b0001 || LED !== 8'hFC)
            $display("FAIL reset_edge1 got DIG=%b LED=%h want 0001 FC", DIG, LED);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (DIG !== 4'b0001) $display("FAIL reset_edge4 got DIG=%b want 0001", DIG);
        else n_pass++;
        step();
        n_total++;
        if (DIG !== 4'b0010) $display("FAIL reset_edge5 got DIG=%b want 0010", DIG);
        else n_pass++;
    endtask

    // Runs across a frame boundary: the value loaded before reset must not appear.
    task automatic test_scan();
        while (edge_n < 20) begin
            step();
            n_total++;
            if (DIG !== (4'b0001 << cur_digit()) || LED !== 8'hFC || FRAME !== 1'b0 || PENDING !== 1'b0)
                $display("FAIL scan edge %0d got DIG=%b LED=%h F=%b P=%b want DIG=%b LED=FC F=0 P=0",
                         edge_n, DIG, LED, FRAME, PENDING, 4'b0001 << cur_digit());
            else n_pass++;
        end
        EN = 1'b0;
        repeat (2) begin
            step();
            n_total++;
            if (DIG !== 4'b0000 || LED !== 8'h00)
                $display("FAIL scan_en_off got DIG=%b LED=%h want 0000 00", DIG, LED);
            else n_pass++;
        end
        EN = 1'b1;
    endtask

    task automatic test_load();
        logic [7:0] exp [4];
        exp[0] = 8'h8E; exp[1] = 8'hEE; exp[2] = 8'hDB; exp[3] = 8'h60;
        step_until(4);
        VALUE = 16'h12AF; DP_IN = 4'b0100; LOAD = 1'b1; step(); LOAD = 1'b0;
        while (edge_n % 16 != 0) begin
            n_total++;
            if (PENDING !== 1'b1 || FRAME !== 1'b0)
                $display("FAIL load_wait edge %0d got P=%b F=%b want P=1 F=0", edge_n, PENDING, FRAME);
            else n_pass++;
            step();
        end
        n_total++;
        if (FRAME !== 1'b1 || PENDING !== 1'b0)
            $display("FAIL load_frame got F=%b P=%b want F=1 P=0", FRAME, PENDING);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            step();
            n_total++;
            if (LED !== exp[cur_digit()] || DIG !== (4'b0001 << cur_digit()) || FRAME !== 1'b0)
                $display("FAIL load_show digit %0d got LED=%h DIG=%b F=%b want LED=%h F=0",
                         cur_digit(), LED, DIG, FRAME, exp[cur_digit()]);
            else n_pass++;
        end
    endtask

    task automatic test_last_wins();
        VALUE = 16'h1111; DP_IN = 4'h0; LOAD = 1'b1; step();
        VALUE = 16'h2222; step(); LOAD = 1'b0;
        n_total++;
        if (PENDING !== 1'b1) $display("FAIL last_wins_pending got %b want 1", PENDING);
        else n_pass++;
        step_until(15); step();
        n_total++;
        if (FRAME !== 1'b1) $display("FAIL last_wins_frame got %b want 1", FRAME);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            step();
            n_total++;
            if (LED !== 8'hDA || DIG !== (4'b0001 << cur_digit()))
                $display("FAIL last_wins_show digit %0d got LED=%h DIG=%b want DA", cur_digit(), LED, DIG);
            else n_pass++;
        end
    endtask

    task automatic test_load_in_b();
        int frames = 0;
        step_until(15);
        VALUE = 16'h0007; DP_IN = 4'h0; LOAD = 1'b1; step(); LOAD = 1'b0;
        n_total++;
        if (FRAME !== 1'b1 || PENDING !== 1'b0)
            $display("FAIL load_in_b got F=%b P=%b want F=1 P=0", FRAME, PENDING);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            step();
            if (FRAME === 1'b1) frames++;
            n_total++;
            if (LED !== ((cur_digit() == 0) ? 8'hE0 : Z_HI) || PENDING !== 1'b0)
                $display("FAIL load_in_b_show digit %0d got LED=%h P=%b want LED=%h P=0",
                         cur_digit(), LED, PENDING, (cur_digit() == 0) ? 8'hE0 : Z_HI);
            else n_pass++;
        end
        n_total++;
        if (frames !== 0) $display("FAIL load_in_b_extra_frame got %0d pulses want 0", frames);
        else n_pass++;
    endtask

    task automatic test_en_off_load();
        EN = 1'b0;
        VALUE = 16'h0003; DP_IN = 4'b0001; LOAD = 1'b1; step(); LOAD = 1'b0;
        n_total++;
        if (PENDING !== 1'b1 || LED !== 8'h00 || DIG !== 4'h0)
            $display("FAIL en_off_load got P=%b LED=%h DIG=%b want 1 00 0000", PENDING, LED, DIG);
        else n_pass++;
        step_until(15); step();
        n_total++;
        if (FRAME !== 1'b1 || PENDING !== 1'b0 || LED !== 8'h00)
            $display("FAIL en_off_frame got F=%b P=%b LED=%h want 1 0 00", FRAME, PENDING, LED);
        else n_pass++;
        EN = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            n_total++;
            if (LED !== ((cur_digit() == 0) ? 8'hF3 : Z_HI))
                $display("FAIL en_off_show digit %0d got LED=%h want %h",
                         cur_digit(), LED, (cur_digit() == 0) ? 8'hF3 : Z_HI);
            else n_pass++;
        end
    endtask

    task automatic test_lzb();
        logic [7:0] exp [4];
        // 0050 with every dp set: blanked digits must drop their dp too.
        exp[0] = 8'hFD; exp[1] = 8'hB7;
`ifdef SEG7_LZB_EN
        exp[2] = 8'h00; exp[3] = 8'h00;
`else
        exp[2] = 8'hFD; exp[3] = 8'hFD;
`endif
        VALUE = 16'h0050; DP_IN = 4'hF; LOAD = 1'b1; step(); LOAD = 1'b0;
        step_until(15); step();
        for (int k = 0; k < 16; k++) begin
            step();
            n_total++;
            if (LED !== exp[cur_digit()] || DIG !== (4'b0001 << cur_digit()))
                $display("FAIL lzb_0050 digit %0d got LED=%h DIG=%b want LED=%h",
                         cur_digit(), LED, DIG, exp[cur_digit()]);
            else n_pass++;
        end
        VALUE = 16'h0000; DP_IN = 4'h0; LOAD = 1'b1; step(); LOAD = 1'b0;
        step_until(15); step();
        for (int k = 0; k < 16; k++) begin
            step();
            n_total++;
            if (LED !== ((cur_digit() == 0) ? 8'hFC : Z_HI) || DIG !== (4'b0001 << cur_digit()))
                $display("FAIL lzb_0000 digit %0d got LED=%h DIG=%b want LED=%h",
                         cur_digit(), LED, DIG, (cur_digit() == 0) ? 8'hFC : Z_HI);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_last_wins();
        test_load_in_b();
        test_en_off_load();
        test_lzb();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
